// File: rtl/fixed_point_divider.sv
// fixed_point_divider: restoring shift-subtract divider, quotient = (dividend << FRAC_BITS) / divisor,
// one quotient bit per clk_audio edge, saturating to all ones. Define ROUND_EN for round-half-up.
module fixed_point_divider #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 20
) (
  input  logic             clk_audio,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  dividend,
  input  logic [IN_W-1:0]  divisor,
  output logic [OUT_W-1:0] quotient,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int N     = IN_W + FRAC_BITS;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     num_q, num_d;
  logic [IN_W:0]    rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [IN_W-1:0]  divisor_q, divisor_d;
  logic [OUT_W-1:0] quotient_q, quotient_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [IN_W:0]    rem_shift;
  logic             quo_bit;
  logic [N:0]       round_inc;
  logic [N:0]       quo_final;
  logic             sat;

  // Datapath helpers: one restoring step and the end-of-operation rounding/saturation.
  always_comb begin
    rem_shift = {rem_q[IN_W-1:0], num_q[N-1]};
    // A set top bit means the shifted remainder already exceeds any divisor.
    quo_bit   = rem_q[IN_W] || (rem_shift >= {1'b0, divisor_q});
    round_inc = '0;
`ifdef ROUND_EN
    round_inc[0] = ({rem_q, 1'b0} >= {2'b00, divisor_q});
`endif
    // One bit wider than the working quotient so a rounding carry is never lost.
    quo_final = {1'b0, quo_q} + round_inc;
    sat       = |quo_final[N:OUT_W];
  end

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    state_d    = state_q;
    count_d    = count_q;
    num_d      = num_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          divisor_d = divisor;
          num_d     = {dividend, {FRAC_BITS{1'b0}}};
          rem_d     = '0;
          quo_d     = '0;
          count_d   = CNT_W'(N);
          dbz_d     = 1'b0;
          state_d   = (divisor == '0) ? S_FINISH : S_RUN;
        end
      end

      S_RUN: begin
        num_d   = num_q << 1;
        quo_d   = {quo_q[N-2:0], quo_bit};
        rem_d   = quo_bit ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = S_FINISH;
      end

      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (divisor_q == '0) begin
          quotient_d = '1;
          dbz_d      = 1'b1;
        end else begin
          quotient_d = sat ? '1 : quo_final[OUT_W-1:0];
          dbz_d      = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset clears working
  // registers too so an abandoned operation leaves nothing behind.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed ratios, error cases, handshake,
// mid-operation reset and randomized operands against a plain-arithmetic reference.
module tb_fixed_point_divider;

  logic        clk_audio = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic [63:0] dividend  = '0;
  logic [63:0] divisor   = '0;
  logic [31:0] quotient;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  fixed_point_divider dut (
    .clk_audio  (clk_audio),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk_audio = ~clk_audio;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact wide integer division, optional round-half-up, then saturation.
  function automatic logic [31:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          output bit dz);
    logic [127:0] num, q, r;
    dz = (b == 64'd0);
    if (dz) return 32'hFFFF_FFFF;
    num = {64'd0, a} << 20;
    q   = num / {64'd0, b};
    r   = num % {64'd0, b};
`ifdef ROUND_EN
    if (2 * r >= {64'd0, b}) q = q + 1;
`endif
    if (q > 128'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  // Wait for done, counting edges from a given starting count; bounded.
  task automatic wait_done(input int first, output int edges);
    edges = first;
    do begin
      @(posedge clk_audio);
      #1;
      edges++;
    end while (!done && edges < 200);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        output logic [31:0] q_obs);
    logic [31:0] exp_q;
    bit          exp_dz;
    int          edges;
    exp_q = ref_div(a, b, exp_dz);
    @(negedge clk_audio);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk_audio);
    #1;
    start = 1'b0;
    dividend = {$urandom(), $urandom()};
    divisor  = {$urandom(), $urandom()};
    check({tag, " dbz_cleared"}, div_by_zero, 1'b0);
    if (!exp_dz) check({tag, " busy"}, busy, 1'b1);
    wait_done(0, edges);
    check({tag, " latency"}, edges, exp_dz ? 1 : 85);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " dbz"}, div_by_zero, exp_dz);
    check({tag, " busy_at_done"}, busy, 1'b0);
    q_obs = quotient;
    @(posedge clk_audio);
    #1;
    check({tag, " single_done"}, done, 1'b0);
    check({tag, " hold"}, quotient, exp_q);
  endtask

  initial begin
    logic [31:0] q;
    logic [63:0] a, b;
    int          edges;
    int          n_done;

    repeat (3) @(posedge clk_audio);
    #1;
    reset = 1'b0;
    check("reset quotient", quotient, 32'd0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dbz", div_by_zero, 1'b0);

    run_op("ratio_1_1", 64'd1 << 20, 64'd1 << 20, q);
    check("ratio_1_1 const", q, 32'h0010_0000);
    run_op("ratio_16_15", 64'd16 << 20, 64'd15 << 20, q);
    check("ratio_16_15 const", q, 32'h0011_1111);
    run_op("ratio_2_3", 64'd2 << 20, 64'd3 << 20, q);
`ifdef ROUND_EN
    check("ratio_2_3 const", q, 32'h000A_AAAB);
`else
    check("ratio_2_3 const", q, 32'h000A_AAAA);
`endif

    run_op("div_zero", 64'd5, 64'd0, q);
    check("div_zero const", q, 32'hFFFF_FFFF);
    run_op("after_div_zero", 64'd1 << 20, 64'd1 << 20, q);
    run_op("saturate", 64'd1 << 40, 64'd1, q);
    check("saturate const", q, 32'hFFFF_FFFF);
    run_op("zero_dividend", 64'd0, 64'd7, q);
    check("zero_dividend const", q, 32'd0);

    // Start pulsed at edge 10 of a running 3:2 operation must be ignored.
    @(negedge clk_audio);
    start = 1'b1; dividend = 64'd3 << 20; divisor = 64'd2 << 20;
    @(posedge clk_audio);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk_audio);
    @(negedge clk_audio);
    start = 1'b1; dividend = 64'd5; divisor = 64'd1;
    @(posedge clk_audio);
    #1;
    start = 1'b0;
    check("busy_start busy", busy, 1'b1);
    wait_done(10, edges);
    check("busy_start latency", edges, 85);
    check("busy_start quotient", quotient, 32'h0018_0000);
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_audio);
      #1;
      if (done) n_done++;
    end
    check("busy_start extra_done", n_done, 0);

    // Reset sampled at edge 40 of an operation abandons it.
    @(negedge clk_audio);
    start = 1'b1; dividend = 64'd1 << 20; divisor = 64'd1 << 20;
    @(posedge clk_audio);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk_audio);
    @(negedge clk_audio);
    reset = 1'b1;
    @(posedge clk_audio);
    #1;
    reset = 1'b0;
    check("mid_reset busy", busy, 1'b0);
    check("mid_reset quotient", quotient, 32'd0);
    check("mid_reset done", done, 1'b0);
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_audio);
      #1;
      if (done) n_done++;
    end
    check("mid_reset no_done", n_done, 0);
    run_op("post_reset_1_1", 64'd1 << 20, 64'd1 << 20, q);
    check("post_reset const", q, 32'h0010_0000);

    for (int i = 0; i < 24; i++) begin
      a = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (i % 8 == 7) b = 64'd0;
      run_op("random", a, b, q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
